// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings and parity-mode codes.
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } uart_state_e;

   localparam logic [1:0] PAR_NONE = 2'b00;
   localparam logic [1:0] PAR_EVEN = 2'b01;
   localparam logic [1:0] PAR_ODD  = 2'b10;

   // Mode 2'b11 is reserved and behaves like PAR_NONE.
   function automatic logic has_parity(input logic [1:0] mode);
      return (mode == PAR_EVEN) || (mode == PAR_ODD);
   endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts CLK_DIV clocks while enabled and pulses bit_tick
// on the last clock of each bit. A sync clear realigns it to a frame start.
module uart_baud_gen #(
   parameter int CLK_DIV = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic clr,
   output logic bit_tick
);

   localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Terminal-count detect; only meaningful while a frame is running.
   always_comb bit_tick = en && (cnt_q == CNT_LAST);

   // Next count: clear on accept, wrap at terminal value, hold at 0 when idle.
   always_comb begin
      cnt_d = cnt_q;
      if (clr || !en || bit_tick) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Count register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: valid/ready word intake, frame build
// (start, LSB-first data, optional parity, 1 or 2 stops) and serialisation.
//
// state     | meaning
// ----------+--------------------------------------------------
// ST_IDLE   | line high, tx_ready=1, waiting for a word
// ST_START  | driving start bit (0)
// ST_DATA   | shifting DATA_W data bits, LSB first
// ST_PARITY | driving parity bit (only when parity enabled)
// ST_STOP   | driving 1 or 2 stop bits (1)
module uart_tx_param
   import uart_pkg::*;
#(
   parameter int DATA_W  = 8,
   parameter int CLK_DIV = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_valid,
   output logic              tx_ready,
   input  logic [1:0]        parity_mode,
   input  logic              two_stop,
   output logic              tx,
   output logic              busy
);

   localparam int BC_W = $clog2(DATA_W + 1);
   localparam logic [BC_W-1:0] BC_LAST = BC_W'(DATA_W - 1);

   uart_state_e       state_q, state_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic [BC_W-1:0]   bit_cnt_q, bit_cnt_d;
   logic [1:0]        par_mode_q, par_mode_d;
   logic              two_stop_q, two_stop_d;
   logic              par_bit_q, par_bit_d;
   logic              tx_q, tx_d;
   logic              busy_q, busy_d;
   logic              accept;
   logic              bit_tick;

   assign tx_ready = (state_q == ST_IDLE);
   assign accept   = tx_valid && tx_ready;
   assign tx       = tx_q;
   assign busy     = busy_q;

   uart_baud_gen #(.CLK_DIV(CLK_DIV)) u_baud (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (state_q != ST_IDLE),
      .clr      (accept),
      .bit_tick (bit_tick)
   );

   // Next-state, shadow config capture and registered tx/busy values.
   always_comb begin
      state_d    = state_q;
      shift_d    = shift_q;
      bit_cnt_d  = bit_cnt_q;
      par_mode_d = par_mode_q;
      two_stop_d = two_stop_q;
      par_bit_d  = par_bit_q;
      tx_d       = tx_q;
      busy_d     = busy_q;
      unique case (state_q)
         ST_IDLE: begin
            tx_d = 1'b1;
            if (accept) begin
               state_d    = ST_START;
               shift_d    = tx_data;
               par_mode_d = parity_mode;
               two_stop_d = two_stop;
               par_bit_d  = (parity_mode == PAR_ODD) ? ~^tx_data : ^tx_data;
               bit_cnt_d  = '0;
               tx_d       = 1'b0;
               busy_d     = 1'b1;
            end
         end
         ST_START: begin
            if (bit_tick) begin
               state_d   = ST_DATA;
               tx_d      = shift_q[0];
               shift_d   = shift_q >> 1;
               bit_cnt_d = '0;
            end
         end
         ST_DATA: begin
            if (bit_tick) begin
               if (bit_cnt_q == BC_LAST) begin
                  bit_cnt_d = '0;
                  if (has_parity(par_mode_q)) begin
                     state_d = ST_PARITY;
                     tx_d    = par_bit_q;
                  end else begin
                     state_d = ST_STOP;
                     tx_d    = 1'b1;
                  end
               end else begin
                  bit_cnt_d = bit_cnt_q + BC_W'(1);
                  tx_d      = shift_q[0];
                  shift_d   = shift_q >> 1;
               end
            end
         end
         ST_PARITY: begin
            if (bit_tick) begin
               state_d = ST_STOP;
               tx_d    = 1'b1;
            end
         end
         ST_STOP: begin
            if (bit_tick) begin
               // bit_cnt reused to count the optional second stop bit
               if (two_stop_q && (bit_cnt_q == '0)) begin
                  bit_cnt_d = BC_W'(1);
               end else begin
                  state_d   = ST_IDLE;
                  bit_cnt_d = '0;
                  busy_d    = 1'b0;
               end
            end
         end
         default: begin
            state_d   = ST_IDLE;
            bit_cnt_d = '0;
            tx_d      = 1'b1;
            busy_d    = 1'b0;
         end
      endcase
   end

   // State, datapath and output registers; reset abandons any frame in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         shift_q    <= '0;
         bit_cnt_q  <= '0;
         par_mode_q <= PAR_NONE;
         two_stop_q <= 1'b0;
         par_bit_q  <= 1'b0;
         tx_q       <= 1'b1;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         shift_q    <= shift_d;
         bit_cnt_q  <= bit_cnt_d;
         par_mode_q <= par_mode_d;
         two_stop_q <= two_stop_d;
         par_bit_q  <= par_bit_d;
         tx_q       <= tx_d;
         busy_q     <= busy_d;
      end
   end

endmodule
